// File: rtl/ca_code_gen_multi.sv
// Multi-channel GPS C/A code generator.
// Each channel runs its own G1/G2 LFSR pair and 10-bit chip counter, stepped by a
// shared chip-rate strobe. A single command port loads PRNs, applies one-chip
// code-phase slews (DELAY/ADVANCE) and disables channels.
module ca_code_gen_multi #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chip_en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [1:0]           cfg_cmd,
    input  logic [5:0]           cfg_prn,
    output logic [NUM_CH-1:0]    chip_out,
    output logic [NUM_CH-1:0]    epoch,
    output logic [NUM_CH-1:0]    ch_active,
    output logic [NUM_CH*10-1:0] chip_idx
);

    localparam logic [1:0] CMD_LOAD    = 2'b00;
    localparam logic [1:0] CMD_DELAY   = 2'b01;
    localparam logic [1:0] CMD_ADVANCE = 2'b10;
    localparam logic [1:0] CMD_DISABLE = 2'b11;
    localparam logic [9:0] ALL_ONES    = 10'h3FF;
    localparam logic [9:0] LAST_IDX    = 10'd1022;

    // Bit k-1 of the LFSR vectors holds register stage k; stage 10 is bit 9.
    typedef struct packed {
        logic [9:0] g1;
        logic [9:0] g2;
        logic [9:0] idx;
        logic       wrap;
    } ch_state_t;

    // One chip of progress; the code period is 1023 chips, so index 1022 wraps
    // back to 0 with both registers reloaded to the all-ones epoch state.
    function automatic ch_state_t chip_step(input ch_state_t s);
        ch_state_t r;
        r      = s;
        r.wrap = 1'b0;
        if (s.idx == LAST_IDX) begin
            r.idx  = '0;
            r.g1   = ALL_ONES;
            r.g2   = ALL_ONES;
            r.wrap = 1'b1;
        end else begin
            r.idx = s.idx + 10'd1;
            r.g1  = {s.g1[8:0], s.g1[2] ^ s.g1[9]};
            r.g2  = {s.g2[8:0], s.g2[1] ^ s.g2[2] ^ s.g2[5] ^ s.g2[7] ^ s.g2[8] ^ s.g2[9]};
        end
        return r;
    endfunction

    function automatic logic [9:0] taps(input int s1, input int s2);
        return (10'd1 << (s1 - 1)) | (10'd1 << (s2 - 1));
    endfunction

    // G2 phase-selector taps; a zero mask marks an unsupported PRN.
    function automatic logic [9:0] prn_mask(input logic [5:0] prn);
        case (prn)
            6'd1:  return taps(2, 6);   6'd2:  return taps(3, 7);
            6'd3:  return taps(4, 8);   6'd4:  return taps(5, 9);
            6'd5:  return taps(1, 9);   6'd6:  return taps(2, 10);
            6'd7:  return taps(1, 8);   6'd8:  return taps(2, 9);
            6'd9:  return taps(3, 10);  6'd10: return taps(2, 3);
            6'd11: return taps(3, 4);   6'd12: return taps(5, 6);
            6'd13: return taps(6, 7);   6'd14: return taps(7, 8);
            6'd15: return taps(8, 9);   6'd16: return taps(9, 10);
            6'd17: return taps(1, 4);   6'd18: return taps(2, 5);
            6'd19: return taps(3, 6);   6'd20: return taps(4, 7);
            6'd21: return taps(5, 8);   6'd22: return taps(6, 9);
            6'd23: return taps(1, 3);   6'd24: return taps(4, 6);
            6'd25: return taps(5, 7);   6'd26: return taps(6, 8);
            6'd27: return taps(7, 9);   6'd28: return taps(8, 10);
            6'd29: return taps(1, 6);   6'd30: return taps(2, 7);
            6'd31: return taps(3, 8);   6'd32: return taps(4, 9);
            default: return '0;
        endcase
    endfunction

    logic [9:0]        g1_q   [NUM_CH];
    logic [9:0]        g1_d   [NUM_CH];
    logic [9:0]        g2_q   [NUM_CH];
    logic [9:0]        g2_d   [NUM_CH];
    logic [9:0]        idx_q  [NUM_CH];
    logic [9:0]        idx_d  [NUM_CH];
    logic [9:0]        mask_q [NUM_CH];
    logic [9:0]        mask_d [NUM_CH];
    logic [NUM_CH-1:0] act_q, act_d;
    logic [NUM_CH-1:0] hold_q, hold_d;
    logic [NUM_CH-1:0] skip_q, skip_d;
    logic [NUM_CH-1:0] epoch_q, epoch_d;
    logic [NUM_CH-1:0] chip_q, chip_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              accept;
    ch_state_t         one_step [NUM_CH];
    ch_state_t         two_step [NUM_CH];

    assign accept = cfg_valid && cfg_ready_q;

    // Candidate single and double chip advances for every channel.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            one_step[n] = chip_step({g1_q[n], g2_q[n], idx_q[n], 1'b0});
            two_step[n] = chip_step(one_step[n]);
        end
    end

    // Per-channel next state: an addressed command wins over the chip strobe.
    always_comb begin
        cfg_ready_d = !accept;
        act_d       = act_q;
        hold_d      = hold_q;
        skip_d      = skip_q;
        epoch_d     = '0;
        chip_d      = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            g1_d[n]   = g1_q[n];
            g2_d[n]   = g2_q[n];
            idx_d[n]  = idx_q[n];
            mask_d[n] = mask_q[n];
            if (accept && (int'(cfg_ch) == n)) begin
                case (cfg_cmd)
                    CMD_LOAD: begin
                        if (prn_mask(cfg_prn) != '0) begin
                            g1_d[n]   = ALL_ONES;
                            g2_d[n]   = ALL_ONES;
                            idx_d[n]  = '0;
                            mask_d[n] = prn_mask(cfg_prn);
                            act_d[n]  = 1'b1;
                            hold_d[n] = 1'b0;
                            skip_d[n] = 1'b0;
                        end else begin
                            act_d[n] = 1'b0;
                        end
                    end
                    CMD_DELAY: begin
                        hold_d[n] = 1'b1;
                        skip_d[n] = 1'b0;
                    end
                    CMD_ADVANCE: begin
                        skip_d[n] = 1'b1;
                        hold_d[n] = 1'b0;
                    end
                    CMD_DISABLE: act_d[n] = 1'b0;
                    default: ;
                endcase
            end else if (chip_en && act_q[n]) begin
                if (hold_q[n]) begin
                    hold_d[n] = 1'b0;
                end else if (skip_q[n]) begin
                    skip_d[n]  = 1'b0;
                    g1_d[n]    = two_step[n].g1;
                    g2_d[n]    = two_step[n].g2;
                    idx_d[n]   = two_step[n].idx;
                    epoch_d[n] = one_step[n].wrap | two_step[n].wrap;
                end else begin
                    g1_d[n]    = one_step[n].g1;
                    g2_d[n]    = one_step[n].g2;
                    idx_d[n]   = one_step[n].idx;
                    epoch_d[n] = one_step[n].wrap;
                end
            end
            chip_d[n] = act_d[n] & (g1_d[n][9] ^ (^(g2_d[n] & mask_d[n])));
        end
    end

    // State and output registers; reset aborts every channel immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_CH; n++) begin
                g1_q[n]   <= ALL_ONES;
                g2_q[n]   <= ALL_ONES;
                idx_q[n]  <= '0;
                mask_q[n] <= '0;
            end
            act_q       <= '0;
            hold_q      <= '0;
            skip_q      <= '0;
            epoch_q     <= '0;
            chip_q      <= '0;
            cfg_ready_q <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                g1_q[n]   <= g1_d[n];
                g2_q[n]   <= g2_d[n];
                idx_q[n]  <= idx_d[n];
                mask_q[n] <= mask_d[n];
            end
            act_q       <= act_d;
            hold_q      <= hold_d;
            skip_q      <= skip_d;
            epoch_q     <= epoch_d;
            chip_q      <= chip_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    // Pack the per-channel chip counters onto the flat output bus.
    always_comb begin
        chip_idx = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            chip_idx[n*10 +: 10] = idx_q[n];
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign chip_out  = chip_q;
    assign epoch     = epoch_q;
    assign ch_active = act_q;

endmodule

// File: tb/tb_ca_code_gen_multi.sv
// Directed testbench for ca_code_gen_multi (4 channels).
module tb_ca_code_gen_multi;

    localparam logic [1:0] LOAD = 2'b00, DELAY = 2'b01, ADVANCE = 2'b10, DISABLE = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chip_en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_cmd = '0;
    logic [5:0]  cfg_prn = '0;
    logic [3:0]  chip_out, epoch, ch_active;
    logic [39:0] chip_idx;

    int checks = 0;
    int errors = 0;

    ca_code_gen_multi #(.NUM_CH(4), .CH_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .chip_en(chip_en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_cmd(cfg_cmd), .cfg_prn(cfg_prn), .chip_out(chip_out),
        .epoch(epoch), .ch_active(ch_active), .chip_idx(chip_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        chip_en = 1'b1;
        step();
        chip_en = 1'b0;
    endtask

    task automatic chips(input int n);
        chip_en = 1'b1;
        repeat (n) step();
        chip_en = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] ch, input logic [1:0] c, input logic [5:0] prn);
        int t = 0;
        while (cfg_ready !== 1'b1 && t < 8) begin
            step();
            t++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait got %b want 1", cfg_ready);
        end
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_cmd   = c;
        cfg_prn   = prn;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++;
        if ({chip_out, epoch, ch_active} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h want 000", {chip_out, epoch, ch_active});
        end
        checks++;
        if (chip_idx !== 40'h0) begin
            errors++;
            $display("FAIL reset_chip_idx got %h want 0", chip_idx);
        end
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b want 0", cfg_ready);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got %b want 1", cfg_ready);
        end
    endtask

    task automatic test_prn_sequences();
        logic [9:0] seq0 = '0;
        logic [9:0] seq1 = '0;
        send_cmd(2'd0, LOAD, 6'd1);
        send_cmd(2'd1, LOAD, 6'd2);
        checks++;
        if (ch_active !== 4'b0011) begin
            errors++;
            $display("FAIL load_active got %b want 0011", ch_active);
        end
        for (int k = 0; k < 10; k++) begin
            seq0 = {seq0[8:0], chip_out[0]};
            seq1 = {seq1[8:0], chip_out[1]};
            pulse();
        end
        checks++;
        if (seq0 !== 10'b1100100000) begin
            errors++;
            $display("FAIL prn1_chips got %b want 1100100000", seq0);
        end
        checks++;
        if (seq1 !== 10'b1110010000) begin
            errors++;
            $display("FAIL prn2_chips got %b want 1110010000", seq1);
        end
        checks++;
        if (chip_idx !== {10'd0, 10'd0, 10'd10, 10'd10}) begin
            errors++;
            $display("FAIL idx_after_10 got %h want %h", chip_idx, {10'd0, 10'd0, 10'd10, 10'd10});
        end
        checks++;
        if (chip_out[3:2] !== 2'b00) begin
            errors++;
            $display("FAIL idle_chip_out got %b want 00", chip_out[3:2]);
        end
    endtask

    task automatic test_epoch();
        logic [9:0] seq0 = '0;
        chips(1012);
        checks++;
        if (chip_idx[9:0] !== 10'd1022 || epoch !== 4'b0000) begin
            errors++;
            $display("FAIL pre_wrap got idx %0d epoch %b want 1022 0000", chip_idx[9:0], epoch);
        end
        pulse();
        checks++;
        if (epoch !== 4'b0011 || chip_idx[9:0] !== 10'd0) begin
            errors++;
            $display("FAIL wrap got epoch %b idx %0d want 0011 0", epoch, chip_idx[9:0]);
        end
        step();
        checks++;
        if (epoch !== 4'b0000) begin
            errors++;
            $display("FAIL epoch_width got %b want 0000", epoch);
        end
        for (int k = 0; k < 10; k++) begin
            seq0 = {seq0[8:0], chip_out[0]};
            pulse();
        end
        checks++;
        if (seq0 !== 10'b1100100000) begin
            errors++;
            $display("FAIL prn1_repeat got %b want 1100100000", seq0);
        end
    endtask

    task automatic test_delay_advance();
        send_cmd(2'd0, LOAD, 6'd1);
        send_cmd(2'd1, LOAD, 6'd1);
        send_cmd(2'd2, LOAD, 6'd1);
        chips(100);
        checks++;
        if (chip_idx[29:0] !== {10'd100, 10'd100, 10'd100}) begin
            errors++;
            $display("FAIL idx_100 got %h want %h", chip_idx[29:0], {10'd100, 10'd100, 10'd100});
        end
        send_cmd(2'd0, DELAY, 6'd0);
        send_cmd(2'd1, ADVANCE, 6'd0);
        chips(922);
        checks++;
        if (epoch !== 4'b0010 || chip_idx[29:0] !== {10'd1022, 10'd0, 10'd1021}) begin
            errors++;
            $display("FAIL advanced_epoch got %b %h want 0010 %h", epoch, chip_idx[29:0], {10'd1022, 10'd0, 10'd1021});
        end
        pulse();
        checks++;
        if (epoch !== 4'b0100) begin
            errors++;
            $display("FAIL reference_epoch got %b want 0100", epoch);
        end
        pulse();
        checks++;
        if (epoch !== 4'b0001) begin
            errors++;
            $display("FAIL delayed_epoch got %b want 0001", epoch);
        end
        chips(1021);
        send_cmd(2'd2, ADVANCE, 6'd0);
        pulse();
        checks++;
        if (epoch[2] !== 1'b1 || chip_idx[29:20] !== 10'd1 || chip_out[2] !== 1'b1) begin
            errors++;
            $display("FAIL advance_over_wrap got ep %b idx %0d chip %b want 1 1 1", epoch[2], chip_idx[29:20], chip_out[2]);
        end
        // ch0 sits at 1022, ch1 at 1: DELAY on ch0 arrives with the chip strobe.
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_cmd   = DELAY;
        chip_en   = 1'b1;
        step();
        cfg_valid = 1'b0;
        chip_en   = 1'b0;
        checks++;
        if (chip_idx[19:0] !== {10'd2, 10'd1022}) begin
            errors++;
            $display("FAIL cmd_with_chip got %h want %h", chip_idx[19:0], {10'd2, 10'd1022});
        end
        pulse();
        checks++;
        if (chip_idx[19:0] !== {10'd3, 10'd1022} || epoch[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_consumed got %h ep %b want %h 0", chip_idx[19:0], epoch[0], {10'd3, 10'd1022});
        end
        pulse();
        checks++;
        if (chip_idx[19:0] !== {10'd4, 10'd0} || epoch[0] !== 1'b1) begin
            errors++;
            $display("FAIL after_hold got %h ep %b want %h 1", chip_idx[19:0], epoch[0], {10'd4, 10'd0});
        end
        send_cmd(2'd1, DELAY, 6'd0);
        send_cmd(2'd1, ADVANCE, 6'd0);
        pulse();
        checks++;
        if (chip_idx[19:10] !== 10'd6) begin
            errors++;
            $display("FAIL overwrite_advance got %0d want 6", chip_idx[19:10]);
        end
        pulse();
        checks++;
        if (chip_idx[19:10] !== 10'd7) begin
            errors++;
            $display("FAIL skip_cleared got %0d want 7", chip_idx[19:10]);
        end
    endtask

    task automatic test_invalid_prn();
        logic [5:0] pat = '0;
        send_cmd(2'd3, LOAD, 6'd5);
        checks++;
        if (ch_active[3] !== 1'b1 || chip_out[3] !== 1'b1) begin
            errors++;
            $display("FAIL prn5_load got act %b chip %b want 1 1", ch_active[3], chip_out[3]);
        end
        pulse();
        send_cmd(2'd3, LOAD, 6'd40);
        checks++;
        if (ch_active[3] !== 1'b0 || chip_out[3] !== 1'b0) begin
            errors++;
            $display("FAIL prn40 got act %b chip %b want 0 0", ch_active[3], chip_out[3]);
        end
        pulse();
        checks++;
        if (chip_idx[39:30] !== 10'd1 || chip_out[3] !== 1'b0) begin
            errors++;
            $display("FAIL frozen_ch3 got idx %0d chip %b want 1 0", chip_idx[39:30], chip_out[3]);
        end
        send_cmd(2'd3, LOAD, 6'd5);
        send_cmd(2'd3, LOAD, 6'd0);
        checks++;
        if (ch_active[3] !== 1'b0 || chip_out[3] !== 1'b0 || chip_idx[39:30] !== 10'd0) begin
            errors++;
            $display("FAIL prn0 got act %b chip %b idx %0d want 0 0 0", ch_active[3], chip_out[3], chip_idx[39:30]);
        end
        send_cmd(2'd1, DISABLE, 6'd0);
        pulse();
        checks++;
        if (ch_active !== 4'b0101 || chip_out[1] !== 1'b0 || chip_idx[19:10] !== 10'd9) begin
            errors++;
            $display("FAIL disable got act %b chip %b idx %0d want 0101 0 9", ch_active, chip_out[1], chip_idx[19:10]);
        end
        step();
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_cmd   = DISABLE;
        for (int k = 0; k < 6; k++) begin
            pat = {pat[4:0], cfg_ready};
            step();
        end
        cfg_valid = 1'b0;
        checks++;
        if (pat !== 6'b101010) begin
            errors++;
            $display("FAIL back_to_back_ready got %b want 101010", pat);
        end
    endtask

    task automatic test_reset_midrun();
        send_cmd(2'd0, LOAD, 6'd1);
        chips(500);
        checks++;
        if (chip_idx[9:0] !== 10'd500) begin
            errors++;
            $display("FAIL idx_500 got %0d want 500", chip_idx[9:0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({chip_out, epoch, ch_active} !== 12'h000 || chip_idx !== 40'h0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %h %h %b want 000 0 0", {chip_out, epoch, ch_active}, chip_idx, cfg_ready);
        end
        repeat (2) step();
        rst_n = 1'b1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b want 0", cfg_ready);
        end
        step();
        checks++;
        if (cfg_ready !== 1'b1 || ch_active !== 4'b0000) begin
            errors++;
            $display("FAIL ready_after_midrun got %b act %b want 1 0000", cfg_ready, ch_active);
        end
    endtask

    initial begin
        test_reset();
        test_prn_sequences();
        test_epoch();
        test_delay_advance();
        test_invalid_prn();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
